packetram_arbiter: RTL and testbench
====================================

# packetram_arbiter

Ownership controller and read aligner for one packet buffer RAM (dual-read, single-write, 1-cycle read latency, read-first). It gives the buffer to the packet snooper for filling and then to the BPF CPU for reading, one side at a time, using a ready/done handshake. It also tracks the packet length and turns CPU byte/half/word reads at any byte address into a single pipelined access using both RAM read ports.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, RAM word-address width; the buffer holds 2**ADDR_WIDTH 32-bit words.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `sn_addr` in ADDR_WIDTH: snooper word address.
- `sn_wr_data` in 32: snooper write data.
- `sn_wr_en` in 1: snooper write strobe.
- `sn_done` in 1: one-cycle pulse meaning the packet is complete.
- `sn_ready` out 1: buffer is owned by the snooper (FILL state).
- `cpu_byte_addr` in ADDR_WIDTH+2: CPU byte address.
- `cpu_trans_len` in 2: transfer size; 0 = byte, 1 = half, 2 = word, 3 = word.
- `cpu_rd_en` in 1: CPU read strobe.
- `cpu_done` in 1: one-cycle pulse releasing the buffer.
- `cpu_ready` out 1: buffer is owned by the CPU (FULL state).
- `cpu_rd_data` out 32: right-justified, zero-extended read result.
- `cpu_rd_valid` out 1: `cpu_rd_data` is valid this cycle.
- `pkt_len` out ADDR_WIDTH+1: packet length in words.
- `ram_en` out 1, `ram_wr_en` out 1, `ram_addra` out ADDR_WIDTH, `ram_addrb` out ADDR_WIDTH, `ram_dia` out 32: RAM control, address and write-data outputs.
- `ram_doa` in 32, `ram_dob` in 32: RAM read data.

## Operation
- State machine, two states:
  - FILL: the snooper owns the buffer.
  - FULL: the CPU owns the buffer.
- Reset enters FILL.
- FILL → FULL when `sn_done`=1. FULL → FILL when `cpu_done`=1. `sn_done` is ignored in FULL; `cpu_done` is ignored in FILL.
- `sn_ready` = (state==FILL). `cpu_ready` = (state==FULL). Both are registered outputs.
- Write path, accepted only when state==FILL and `sn_wr_en`=1:
  - `ram_wr_en`=1, `ram_addra`=`sn_addr`, `ram_dia`=`sn_wr_data`.
  - In FULL, `sn_wr_en` is dropped and `ram_wr_en` stays 0.
- A write in the same cycle as `sn_done` is accepted, then the state changes.
- Length tracking:
  - On each accepted write, `pkt_len` ← max(`pkt_len`, `sn_addr`+1), computed at ADDR_WIDTH+1 bits with no overflow.
  - `pkt_len` clears to 0 on the FULL→FILL transition.
  - `pkt_len` holds its value throughout FULL.
- Read path, accepted only when state==FULL and `cpu_rd_en`=1:
  - Word address w = `cpu_byte_addr`[ADDR_WIDTH+1:2].
  - `ram_addra`=w and `ram_addrb`=w+1, wrapping modulo 2**ADDR_WIDTH (the top word pairs with word 0).
  - `cpu_rd_en` is dropped in FILL.
  - Offset (`cpu_byte_addr`[1:0]) and `cpu_trans_len` are captured in a pipeline register.
- A read in the same cycle as `cpu_done` is accepted and completes normally; the state changes to FILL.
- `ram_en` = accepted write OR accepted read. The RAM is idle otherwise.
- Alignment, big-endian (byte 0 of a word is bits [31:24]):
  - cat = {`ram_doa`,`ram_dob`}; t = (cat << 8*offset)[63:32].
  - Byte read: {24'b0, t[31:24]}. Half read: {16'b0, t[31:16]}. Word read: t.
- Reads past `pkt_len` are not checked; they return RAM contents.

## Timing
- Read latency is 2 cycles:
  - Cycle N: `cpu_rd_en` is accepted and addresses are driven.
  - Cycle N+1: RAM data is available.
  - Cycle N+2: `cpu_rd_valid`=1 for one cycle with registered `cpu_rd_data`.
- Fully pipelined: one read may be accepted every cycle.
- Write takes effect at the clock edge of the accepting cycle.
- Ownership switches at the clock edge after `sn_done`/`cpu_done`. The ready outputs change on that same edge.
- Reset values: state FILL, `sn_ready`=1, `cpu_ready`=0, `cpu_rd_valid`=0, `cpu_rd_data`=0, `pkt_len`=0, read pipeline cleared.
- RAM control outputs are combinational from the inputs and state, so they are 0 during reset.
- Reset mid-read flushes the pipeline: no `cpu_rd_valid` is produced for reads accepted before reset.

## Structure
- Shared package `bpf_mem_pkg`:
  - Transfer-length encodings: `LEN_BYTE`=0, `LEN_HALF`=1, `LEN_WORD`=2.
  - State encoding: FILL, FULL.
  - Data width constant: 32.
- One sub-module, `packet_read_align`: captures offset and length at cycle N, then registers the shifted and zero-extended result with `cpu_rd_valid` at cycle N+2.
- FSM, length tracker and RAM muxing live in the top level.

## Test plan
- Reset, write words 0..3 = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then pulse `sn_done`:
  - `cpu_ready`=1, `sn_ready`=0, `pkt_len`=4.
- FULL, word read at byte address 5:
  - two cycles later `cpu_rd_data`=0x5566778 8 is wrong spacing; required value is 0x55667788 with `cpu_rd_valid`=1 for one cycle.
- Half read at byte address 7 → 0x00007788. Byte read at byte address 8 → 0x00000088.
- Back-to-back reads at byte addresses 0, 1, 2, 3 (word):
  - four consecutive valid cycles returning 0x00112233, 0x11223344, 0x22334455, 0x33445566.
- Wrap: with ADDR_WIDTH=2 and a word read at byte address 13:
  - addra=3, addrb=0, result 0xDDEEFF00.
- Ownership boundaries:
  - `sn_wr_en` in FULL → RAM word unchanged.
  - `cpu_rd_en` in FILL → no valid output.
  - Read plus `cpu_done` in the same cycle → valid returned, then FILL with `pkt_len`=0.
  - Assert `rst` one cycle after a read → no valid output.

Source files
------------

// File: rtl/bpf_mem_pkg.sv
// Shared definitions for the packet buffer RAM ownership/read-alignment logic.
// Holds transfer-length codes, the ownership state encoding and the big-endian aligner.
package bpf_mem_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } buf_state_t;

    // Byte 0 of a word is bits [31:24]; the two words are concatenated and shifted
    // left so the addressed byte lands in the top byte lane.
    function automatic logic [DATA_WIDTH-1:0] align_data(
        input logic [DATA_WIDTH-1:0] word_a,
        input logic [DATA_WIDTH-1:0] word_b,
        input logic [1:0]            offset,
        input logic [1:0]            trans_len
    );
        logic [2*DATA_WIDTH-1:0] cat;
        logic [2*DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0]   top;
        logic [DATA_WIDTH-1:0]   result;
        cat     = {word_a, word_b};
        shifted = cat << {offset, 3'b000};
        top     = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
        case (trans_len)
            LEN_BYTE: result = {24'h000000, top[31:24]};
            LEN_HALF: result = {16'h0000, top[31:16]};
            LEN_WORD: result = top;
            default:  result = top;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/packet_read_align.sv
// Two-stage read pipeline: holds offset/size while the RAM responds, then
// registers the aligned, zero-extended result together with its valid flag.
module packet_read_align
    import bpf_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_accept,
    input  logic [1:0]            offset,
    input  logic [1:0]            trans_len,
    input  logic [DATA_WIDTH-1:0] ram_doa,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic       pend_valid_r;
    logic [1:0] pend_offset_r;
    logic [1:0] pend_len_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    // Stage 1: remember how to align the data the RAM returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_r  <= 1'b0;
            pend_offset_r <= 2'd0;
            pend_len_r    <= 2'd0;
        end else begin
            pend_valid_r  <= rd_accept;
            pend_offset_r <= offset;
            pend_len_r    <= trans_len;
        end
    end

    // Stage 2: register the aligned result; data only updates on a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= pend_valid_r;
            if (pend_valid_r) begin
                rd_data_r <= align_data(ram_doa, ram_dob, pend_offset_r, pend_len_r);
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: rtl/packetram_arbiter.sv
// Packet buffer owner: the snooper fills the RAM, then the CPU reads it with
// arbitrary byte alignment using both read ports, handing back via done pulses.
module packetram_arbiter
    import bpf_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] sn_addr,
    input  logic [DATA_WIDTH-1:0] sn_wr_data,
    input  logic                  sn_wr_en,
    input  logic                  sn_done,
    output logic                  sn_ready,
    input  logic [ADDR_WIDTH+1:0] cpu_byte_addr,
    input  logic [1:0]            cpu_trans_len,
    input  logic                  cpu_rd_en,
    input  logic                  cpu_done,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_rd_valid,
    output logic [ADDR_WIDTH:0]   pkt_len,
    output logic                  ram_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [DATA_WIDTH-1:0] ram_dia,
    input  logic [DATA_WIDTH-1:0] ram_doa,
    input  logic [DATA_WIDTH-1:0] ram_dob
);

    buf_state_t state_r;
    buf_state_t next_state_s;
    logic       sn_ready_r;
    logic       cpu_ready_r;
    logic [ADDR_WIDTH:0]   pkt_len_r;
    logic [ADDR_WIDTH:0]   cand_len_s;
    logic [ADDR_WIDTH-1:0] rd_word_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;

    assign wr_accept_s = (state_r == FILL) && sn_wr_en;
    assign rd_accept_s = (state_r == FULL) && cpu_rd_en;
    assign rd_word_s   = cpu_byte_addr[ADDR_WIDTH+1:2];
    assign cand_len_s  = {1'b0, sn_addr} + (ADDR_WIDTH+1)'(1);

    // Ownership next-state: each side's done pulse only matters while it owns the buffer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FILL: begin
                if (sn_done) next_state_s = FULL;
                else         next_state_s = FILL;
            end
            FULL: begin
                if (cpu_done) next_state_s = FILL;
                else          next_state_s = FULL;
            end
            default: next_state_s = FILL;
        endcase
    end

    // Ownership state plus ready flags registered from the next state so they switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            sn_ready_r  <= 1'b1;
            cpu_ready_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            sn_ready_r  <= (next_state_s == FILL);
            cpu_ready_r <= (next_state_s == FULL);
        end
    end

    // Packet length: high-water mark of written words, cleared when the CPU releases the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_len_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if ((state_r == FULL) && cpu_done) begin
            pkt_len_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (wr_accept_s && (cand_len_s > pkt_len_r)) begin
            pkt_len_r <= cand_len_s;
        end else begin
            pkt_len_r <= pkt_len_r;
        end
    end

    // RAM port muxing; port B always fetches the following word (wrapping) for misaligned reads.
    always_comb begin
        ram_en    = 1'b0;
        ram_wr_en = 1'b0;
        ram_addra = {ADDR_WIDTH{1'b0}};
        ram_addrb = {ADDR_WIDTH{1'b0}};
        ram_dia   = 32'h0000_0000;
        if (rst) begin
            ram_en = 1'b0;
        end else if (wr_accept_s) begin
            ram_en    = 1'b1;
            ram_wr_en = 1'b1;
            ram_addra = sn_addr;
            ram_dia   = sn_wr_data;
        end else if (rd_accept_s) begin
            ram_en    = 1'b1;
            ram_addra = rd_word_s;
            ram_addrb = rd_word_s + ADDR_WIDTH'(1);
        end else begin
            ram_en = 1'b0;
        end
    end

    packet_read_align u_align (
        .clk       (clk),
        .rst       (rst),
        .rd_accept (rd_accept_s),
        .offset    (cpu_byte_addr[1:0]),
        .trans_len (cpu_trans_len),
        .ram_doa   (ram_doa),
        .ram_dob   (ram_dob),
        .rd_data   (cpu_rd_data),
        .rd_valid  (cpu_rd_valid)
    );

    assign sn_ready  = sn_ready_r;
    assign cpu_ready = cpu_ready_r;
    assign pkt_len   = pkt_len_r;

endmodule

// File: tb/tb_packetram_arbiter.sv
// Self-checking bench for packetram_arbiter with a behavioural read-first RAM
// and a latency-tagged scoreboard of expected read results.
module tb_packetram_arbiter;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sn_addr;
    logic [31:0]   sn_wr_data;
    logic          sn_wr_en, sn_done, sn_ready;
    logic [AW+1:0] cpu_byte_addr;
    logic [1:0]    cpu_trans_len;
    logic          cpu_rd_en, cpu_done, cpu_ready;
    logic [31:0]   cpu_rd_data;
    logic          cpu_rd_valid;
    logic [AW:0]   pkt_len;
    logic          ram_en, ram_wr_en;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_dia, ram_doa, ram_dob;

    packetram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
        .sn_done(sn_done), .sn_ready(sn_ready),
        .cpu_byte_addr(cpu_byte_addr), .cpu_trans_len(cpu_trans_len),
        .cpu_rd_en(cpu_rd_en), .cpu_done(cpu_done), .cpu_ready(cpu_ready),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid), .pkt_len(pkt_len),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_addra(ram_addra),
        .ram_addrb(ram_addrb), .ram_dia(ram_dia), .ram_doa(ram_doa), .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: dual read, single write on port A, read-first, 1-cycle latency.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_doa <= mem[ram_addra];
            ram_dob <= mem[ram_addrb];
            if (ram_wr_en) mem[ram_addra] <= ram_dia;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [AW+1:0] addr;
        logic [1:0]    len;
        logic [31:0]   exp;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid beat must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (cpu_rd_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got data %h with no read outstanding", cpu_rd_data);
                end else begin
                    e = sbq.pop_front();
                    check("rd_data", cpu_rd_data, e.data);
                    check("rd_latency_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: got no valid at cycle %0d, expected data %h", cyc, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic done);
        sn_addr = a; sn_wr_data = d; sn_wr_en = 1'b1; sn_done = done;
        #1;
        check("wr_ram_en", {31'd0, ram_en}, 32'd1);
        check("wr_ram_wr_en", {31'd0, ram_wr_en}, 32'd1);
        check("wr_ram_addra", 32'(ram_addra), 32'(a));
        check("wr_ram_dia", ram_dia, d);
        @(posedge clk);
        #1;
        sn_wr_en = 1'b0; sn_done = 1'b0;
    endtask

    task automatic do_read(input logic [AW+1:0] ba, input logic [1:0] len, input logic [31:0] exp);
        logic [AW-1:0] w;
        w = ba[AW+1:2];
        cpu_byte_addr = ba; cpu_trans_len = len; cpu_rd_en = 1'b1;
        sbq.push_back('{exp, cyc + 2});
        #1;
        check("rd_ram_en", {31'd0, ram_en}, 32'd1);
        check("rd_ram_addra", 32'(ram_addra), 32'(w));
        check("rd_ram_addrb", 32'(ram_addrb), 32'((int'(w) + 1) % (1 << AW)));
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        ram_doa = 32'h0; ram_dob = 32'h0;
        sn_addr = '0; sn_wr_data = 32'h0; sn_wr_en = 1'b0; sn_done = 1'b0;
        cpu_byte_addr = '0; cpu_trans_len = 2'd0; cpu_rd_en = 1'b0; cpu_done = 1'b0;
        rst = 1'b1;

        vt[0]  = '{4'd5,  2'd2, 32'h55667788};
        vt[1]  = '{4'd7,  2'd1, 32'h00007788};
        vt[2]  = '{4'd8,  2'd0, 32'h00000088};
        vt[3]  = '{4'd0,  2'd2, 32'h00112233};
        vt[4]  = '{4'd1,  2'd2, 32'h11223344};
        vt[5]  = '{4'd2,  2'd2, 32'h22334455};
        vt[6]  = '{4'd3,  2'd2, 32'h33445566};
        vt[7]  = '{4'd13, 2'd2, 32'hDDEEFF00};
        vt[8]  = '{4'd15, 2'd0, 32'h000000FF};
        vt[9]  = '{4'd14, 2'd1, 32'h0000EEFF};
        vt[10] = '{4'd2,  2'd3, 32'h22334455};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_sn_ready", {31'd0, sn_ready}, 32'd1);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, cpu_rd_valid}, 32'd0);
        check("rst_rd_data", cpu_rd_data, 32'h0);
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        rst = 1'b0;
        tick();

        // Fill, out of order so the length tracker must keep the maximum.
        do_write(2'd0, 32'h00112233, 1'b0);
        do_write(2'd1, 32'h44556677, 1'b0);
        check("pkt_len_after_w1", 32'(pkt_len), 32'd2);
        do_write(2'd3, 32'hCCDDEEFF, 1'b0);
        check("pkt_len_after_w3", 32'(pkt_len), 32'd4);
        check("still_fill", {31'd0, cpu_ready}, 32'd0);
        do_write(2'd2, 32'h8899AABB, 1'b1);
        check("full_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        check("full_sn_ready", {31'd0, sn_ready}, 32'd0);
        check("full_pkt_len", 32'(pkt_len), 32'd4);

        // Table reads, issued back-to-back.
        for (int i = 0; i < 11; i++) do_read(vt[i].addr, vt[i].len, vt[i].exp);
        repeat (4) tick();

        // Snooper write while the CPU owns the buffer is dropped.
        sn_addr = 2'd0; sn_wr_data = 32'hDEADBEEF; sn_wr_en = 1'b1; sn_done = 1'b1;
        #1;
        check("full_wr_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("full_wr_ram_en", {31'd0, ram_en}, 32'd0);
        tick();
        sn_wr_en = 1'b0; sn_done = 1'b0;
        check("full_ignores_sn_done", {31'd0, cpu_ready}, 32'd1);
        check("full_pkt_len_hold", 32'(pkt_len), 32'd4);
        do_read(4'd0, 2'd2, 32'h00112233);
        repeat (3) tick();

        // Read in the same cycle as cpu_done completes, then ownership returns.
        cpu_done = 1'b1;
        do_read(4'd4, 2'd2, 32'h44556677);
        cpu_done = 1'b0;
        check("release_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("release_sn_ready", {31'd0, sn_ready}, 32'd1);
        check("release_pkt_len", 32'(pkt_len), 32'd0);
        repeat (3) tick();

        // CPU read while the snooper owns the buffer is dropped.
        cpu_byte_addr = 4'd4; cpu_trans_len = 2'd2; cpu_rd_en = 1'b1; cpu_done = 1'b1;
        #1;
        check("fill_rd_ram_en", {31'd0, ram_en}, 32'd0);
        tick();
        cpu_rd_en = 1'b0; cpu_done = 1'b0;
        check("fill_ignores_cpu_done", {31'd0, sn_ready}, 32'd1);
        repeat (3) tick();

        // Reset one cycle after a read flushes it.
        do_write(2'd0, 32'h00112233, 1'b1);
        check("refill_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        do_read(4'd4, 2'd2, 32'h44556677);
        rst = 1'b1;
        sbq.delete();
        tick();
        check("midrst_rd_valid", {31'd0, cpu_rd_valid}, 32'd0);
        check("midrst_sn_ready", {31'd0, sn_ready}, 32'd1);
        check("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
